sha256_host_mem: RTL
====================

Name: sha256_host_mem

Overview:
- Host-side counterpart of the SHA-256 engine's memory master port.
- Owns a word-addressed message/digest RAM and loads NUM_OF_WORDS message words from a host stream.
- Pulses the engine's start, then services the engine's reads and writes with one-cycle read latency.
- Waits for done, then reads the 8 digest words back and streams them out under valid/ready.

Parameters:
- NUM_OF_WORDS, 20: message words loaded per hash job (1..MSG_BASE span limit).
- DEPTH, 256: RAM depth in 32-bit words; address index = mem_addr[7:0], in range iff mem_addr < DEPTH.
- MSG_BASE, 16'h0000: word address driven on message_addr.
- OUT_BASE, 16'h0080: word address driven on output_addr and used for digest readback.
- WAIT_LIMIT, 4096: cycles allowed in WAIT before timeout.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- ld_valid  in  1  host message word valid.
- ld_ready  out  1  block accepts ld_data this cycle.
- ld_data  in  32  message word, loaded in order to MSG_BASE+0..NUM_OF_WORDS-1.
- start  out  1  one-cycle job start to engine.
- message_addr  out  16  constant MSG_BASE.
- output_addr  out  16  constant OUT_BASE.
- done  in  1  engine completion pulse.
- mem_we  in  1  engine write enable.
- mem_addr  in  16  engine word address.
- mem_write_data  in  32  engine write data.
- mem_read_data  out  32  registered read data to engine.
- dig_valid  out  1  digest word valid.
- dig_ready  in  1  host accepts digest word.
- dig_data  out  32  digest word h0..h7, h0 first.
- dig_last  out  1  high with 8th digest word.
- busy  out  1  high in every state except IDLE.
- timeout  out  1  sticky; set on WAIT expiry, cleared on next accepted ld word.

Behaviour:
- Reset: state=IDLE; ld_ready=1, start=0, dig_valid=0, dig_last=0, dig_data=0, mem_read_data=0, busy=0, timeout=0, word count=0, wait counter=0. RAM contents are not reset.
- Reset mid-job abandons the job; RAM keeps its contents.
- RAM port ownership: host FSM owns the port in IDLE, LOAD and the RD_* states; the engine owns it only in KICK and WAIT.
- Engine read: mem_read_data <= RAM[mem_addr] on every posedge while the engine owns the port. Data presented at cycle N is valid at cycle N+1 (one-cycle latency).
- Engine read while the engine does not own the port, or to an out-of-range address: mem_read_data <= 0.
- Engine write: RAM[mem_addr] <= mem_write_data on a posedge with mem_we=1, engine owning the port and address in range. Otherwise the write is dropped.
- Read-during-write to the same address returns the old data.
- IDLE: ld_ready=1. On ld_valid&ld_ready, write RAM[MSG_BASE]=ld_data, set count=1, clear timeout, go to LOAD; if NUM_OF_WORDS==1, go to KICK instead.
- LOAD: ld_ready=1. Each handshake writes RAM[MSG_BASE+count] and increments count. The handshake that makes count==NUM_OF_WORDS goes to KICK.
- ld_ready=0 in all states other than IDLE and LOAD.
- KICK: start=1 for exactly one cycle; clear wait counter; go to WAIT.
- WAIT: increment wait counter each cycle. done=1 goes to RD_ADDR with idx=0; done takes priority if it coincides with the limit. Counter reaching WAIT_LIMIT-1 without done sets timeout=1 and goes to IDLE.
- done outside WAIT is ignored.
- RD_ADDR: internal read of RAM[OUT_BASE+idx]; go to RD_DATA.
- RD_DATA: capture the read word into dig_data, set dig_valid=1, set dig_last=(idx==7); go to STREAM.
- STREAM: hold dig_data, dig_valid and dig_last stable until dig_ready. On the handshake, clear dig_valid; if idx==7, clear dig_last and go to IDLE, else increment idx and go to RD_ADDR.
- Throughput: one digest word per 3 cycles when dig_ready is held high.
- Address arithmetic: 16-bit sums, wrap modulo 2^16, then the in-range check applies.

Test Plan:
- Load 20 words 0x00000001..0x00000014 with ld_valid held high -> ld_ready high for 20 cycles; RAM[0..19] match; start pulses once, 1 cycle after the 20th handshake; busy=1.
- Engine stub reads address 5 at cycle N -> mem_read_data=0x00000006 at N+1. Engine read of address 0x0100 -> 0.
- Engine stub writes 0x11111111*k to 0x0080+k (k=0..7), then pulses done -> dig stream 0x00000000, 0x11111111, ... 0x77777777. dig_last is set only on 0x77777777. Block returns to IDLE.
- dig_ready randomly low for 1-5 cycles during readback -> dig_data, dig_valid and dig_last stable while stalled; no words lost or duplicated.
- WAIT_LIMIT=16 and no done -> timeout=1 after 16 WAIT cycles; state IDLE; a late done is ignored; the next ld handshake clears timeout.
- Reset asserted after 7 of 20 loaded words -> all outputs at reset values next cycle; a fresh 20-word load completes normally. Engine write with mem_we=1 during LOAD -> RAM unchanged.

Source files
------------

// File: rtl/sha256_host_mem.sv
// Host-side partner of the SHA-256 engine memory port. It loads a message into a
// shared word RAM, kicks the engine, serves the engine's accesses and streams the digest back.
module sha256_host_mem #(
  parameter int unsigned NUM_OF_WORDS = 20,
  parameter int unsigned DEPTH        = 256,
  parameter logic [15:0] MSG_BASE     = 16'h0000,
  parameter logic [15:0] OUT_BASE     = 16'h0080,
  parameter int unsigned WAIT_LIMIT   = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_data,
  output logic        start,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr,
  input  logic        done,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        dig_valid,
  input  logic        dig_ready,
  output logic [31:0] dig_data,
  output logic        dig_last,
  output logic        busy,
  output logic        timeout
);
  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WW        = $clog2(WAIT_LIMIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(WAIT_LIMIT - 1);
  localparam logic [15:0] LAST_WORD = 16'(NUM_OF_WORDS - 1);
  localparam logic [16:0] DEPTH_W   = 17'(DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    KICK    = 3'd2,
    WAIT    = 3'd3,
    RD_ADDR = 3'd4,
    RD_DATA = 3'd5,
    STREAM  = 3'd6
  } state_t;

  state_t        state_r, state_s;
  logic [31:0]   ram [DEPTH];
  logic [15:0]   count_r;
  logic [WW-1:0] wait_r;
  logic [2:0]    idx_r;
  logic [31:0]   host_rd_r;
  logic          eng_own_s, ld_fire_s, in_range_s, wr_en_s;
  logic [15:0]   port_addr_s;
  logic [31:0]   wr_data_s;
  logic [AW-1:0] port_idx_s;

  assign message_addr = MSG_BASE;
  assign output_addr  = OUT_BASE;

  // The single RAM port is steered by state: engine in KICK/WAIT, host otherwise.
  always_comb begin
    eng_own_s   = (state_r == KICK) || (state_r == WAIT);
    ld_fire_s   = ld_valid && ld_ready;
    port_addr_s = MSG_BASE;
    wr_data_s   = ld_data;
    wr_en_s     = 1'b0;
    case (state_r)
      IDLE: begin
        port_addr_s = MSG_BASE;
        wr_en_s     = ld_fire_s;
      end
      LOAD: begin
        port_addr_s = MSG_BASE + count_r;
        wr_en_s     = ld_fire_s;
      end
      KICK, WAIT: begin
        port_addr_s = mem_addr;
        wr_data_s   = mem_write_data;
        wr_en_s     = mem_we;
      end
      RD_ADDR, RD_DATA, STREAM: port_addr_s = OUT_BASE + {13'd0, idx_r};
      default: port_addr_s = MSG_BASE;
    endcase
    in_range_s = ({1'b0, port_addr_s} < DEPTH_W);
    port_idx_s = port_addr_s[AW-1:0];
  end

  // Next-state logic for the job sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (ld_fire_s) state_s = (NUM_OF_WORDS == 32'd1) ? KICK : LOAD;
        else           state_s = IDLE;
      end
      LOAD: begin
        if (ld_fire_s && (count_r == LAST_WORD)) state_s = KICK;
        else                                      state_s = LOAD;
      end
      KICK: state_s = WAIT;
      WAIT: begin
        if (done)                  state_s = RD_ADDR;
        else if (wait_r == WAIT_MAX) state_s = IDLE;
        else                       state_s = WAIT;
      end
      RD_ADDR: state_s = RD_DATA;
      RD_DATA: state_s = STREAM;
      STREAM: begin
        if (dig_ready) state_s = (idx_r == 3'd7) ? IDLE : RD_ADDR;
        else           state_s = STREAM;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s && in_range_s && !reset) ram[port_idx_s] <= wr_data_s;
  end

  // Registered outputs, counters and digest readback path.
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_ready      <= 1'b1;
      start         <= 1'b0;
      busy          <= 1'b0;
      timeout       <= 1'b0;
      mem_read_data <= 32'd0;
      dig_valid     <= 1'b0;
      dig_last      <= 1'b0;
      dig_data      <= 32'd0;
      count_r       <= 16'd0;
      wait_r        <= '0;
      idx_r         <= 3'd0;
    end else begin
      ld_ready      <= (state_s == IDLE) || (state_s == LOAD);
      start         <= (state_s == KICK);
      busy          <= (state_s != IDLE);
      mem_read_data <= (eng_own_s && in_range_s) ? ram[port_idx_s] : 32'd0;
      case (state_r)
        IDLE: begin
          if (ld_fire_s) begin
            count_r <= 16'd1;
            timeout <= 1'b0;
          end
        end
        LOAD: begin
          if (ld_fire_s) count_r <= count_r + 16'd1;
        end
        KICK: wait_r <= '0;
        WAIT: begin
          if (done)                    idx_r   <= 3'd0;
          else if (wait_r == WAIT_MAX) timeout <= 1'b1;
          else                         wait_r  <= wait_r + WW'(1);
        end
        RD_ADDR: host_rd_r <= in_range_s ? ram[port_idx_s] : 32'd0;
        RD_DATA: begin
          dig_data  <= host_rd_r;
          dig_valid <= 1'b1;
          dig_last  <= (idx_r == 3'd7);
        end
        STREAM: begin
          if (dig_ready) begin
            dig_valid <= 1'b0;
            dig_last  <= 1'b0;
            if (idx_r != 3'd7) idx_r <= idx_r + 3'd1;
          end
        end
        default: idx_r <= idx_r;
      endcase
    end
  end
endmodule
